// File: rtl/func_test_monitor.sv
// End-of-test monitor for the MIPS function test: classifies the run as PASS/FAIL/TIMEOUT/HANG,
// counts RUN cycles and stores, and keeps a short history of distinct fetch PCs.
module func_test_monitor #(
  parameter int unsigned           DATA_W         = 32,
  parameter logic [DATA_W-1:0]     RESULT_ADDR    = 32'h0000_0050,
  parameter logic [DATA_W-1:0]     PASS_VALUE     = 32'h0000_0007,
  parameter int unsigned           TIMEOUT_CYCLES = 100000,
  parameter int unsigned           HANG_LIMIT     = 64,
  parameter int unsigned           HIST_DEPTH     = 8,
  parameter int unsigned           CNT_W          = 32,
  localparam int unsigned          HW             = $clog2(HIST_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [DATA_W-1:0] fail_value,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count,
  input  logic [HW-1:0]     hist_idx,
  output logic [DATA_W-1:0] hist_pc,
  output logic [HW:0]       hist_cnt
);

  localparam int unsigned SW = $clog2(HANG_LIMIT) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE    = 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]    SAME_ONE   = 1;
  localparam logic [SW-1:0]    SAME_LAST  = SW'(HANG_LIMIT - 1);
  localparam logic [HW-1:0]    PTR_ONE    = 1;
  localparam logic [HW:0]      HCNT_ONE   = 1;
  localparam logic [HW:0]      HIST_FULL  = (HW + 1)'(HIST_DEPTH);

  typedef enum logic [2:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT,
    S_HANG
  } state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] prev_pc;
  logic              prev_valid;
  logic [SW-1:0]     same_cnt;
  logic [HW-1:0]     wp;
  logic [HW-1:0]     rd_ptr;
  logic [DATA_W-1:0] hist_buf [HIST_DEPTH];

  logic running;
  logic result_store;
  logic pc_same;
  logic push;

  assign running      = (state == S_RUN);
  assign result_store = memwrite && (dataadr == RESULT_ADDR);
  assign pc_same      = prev_valid && (pc == prev_pc);
  assign push         = running && !pc_same;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    pass       = 1'b0;
    fail_code  = 2'd0;

    if (running) begin
      if (result_store)
        next_state = (writedata == PASS_VALUE) ? S_PASS : S_FAIL;
      else if (cycle_count == CNT_LAST)
        next_state = S_TIMEOUT;
      else if (pc_same && (same_cnt == SAME_LAST))
        next_state = S_HANG;
    end

    unique case (state)
      S_RUN:     ;
      S_PASS:    begin done = 1'b1; pass = 1'b1; end
      S_FAIL:    begin done = 1'b1; fail_code = 2'd1; end
      S_TIMEOUT: begin done = 1'b1; fail_code = 2'd2; end
      S_HANG:    begin done = 1'b1; fail_code = 2'd3; end
      default:   ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      cycle_count <= '0;
      store_count <= '0;
      fail_value  <= '0;
      prev_pc     <= '0;
      prev_valid  <= 1'b0;
      same_cnt    <= '0;
      wp          <= '0;
      hist_cnt    <= '0;
    end else begin
      state <= next_state;
      if (running) begin
        if (cycle_count != '1)
          cycle_count <= cycle_count + CNT_ONE;
        if (memwrite && (store_count != '1))
          store_count <= store_count + CNT_ONE;
        if (result_store && (writedata != PASS_VALUE))
          fail_value <= writedata;

        prev_pc    <= pc;
        prev_valid <= 1'b1;
        same_cnt   <= pc_same ? same_cnt + SAME_ONE : '0;

        if (push) begin
          wp <= wp + PTR_ONE;
          if (hist_cnt != HIST_FULL)
            hist_cnt <= hist_cnt + HCNT_ONE;
        end
      end
    end
  end

  // NOTE: the history storage is not reset; entries beyond hist_cnt are masked on read instead.
  always_ff @(posedge clk) begin
    if (push && !rst)
      hist_buf[wp] <= pc;
  end

  assign rd_ptr  = wp - PTR_ONE - hist_idx;
  assign hist_pc = ({1'b0, hist_idx} < hist_cnt) ? hist_buf[rd_ptr] : '0;

endmodule

// File: tb/tb_func_test_monitor.sv
// Directed bench for func_test_monitor: pass/fail/timeout/hang verdicts, freezing,
// PC history wrap and mid-run reset, with hand-computed expectations.
module tb_func_test_monitor;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int HW     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] pc = '0;
  logic              memwrite = 1'b0;
  logic [DATA_W-1:0] dataadr = '0;
  logic [DATA_W-1:0] writedata = '0;
  logic              done;
  logic              pass;
  logic [1:0]        fail_code;
  logic [DATA_W-1:0] fail_value;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  store_count;
  logic [HW-1:0]     hist_idx = '0;
  logic [DATA_W-1:0] hist_pc;
  logic [HW:0]       hist_cnt;

  int total = 0;
  int bad   = 0;

  func_test_monitor #(
    .DATA_W(DATA_W), .RESULT_ADDR(32'h50), .PASS_VALUE(32'h7),
    .TIMEOUT_CYCLES(100), .HANG_LIMIT(8), .HIST_DEPTH(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .fail_code(fail_code),
    .fail_value(fail_value), .cycle_count(cycle_count), .store_count(store_count),
    .hist_idx(hist_idx), .hist_pc(hist_pc), .hist_cnt(hist_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] val);
    memwrite  = 1'b1;
    dataadr   = adr;
    writedata = val;
  endtask

  task automatic read_hist(input string tag, input int idx, input logic [31:0] exp);
    hist_idx = HW'(idx);
    #1;
    check(tag, hist_pc, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " done"}, done, 0);
    check({tag, " pass"}, pass, 0);
    check({tag, " fail_code"}, fail_code, 0);
    check({tag, " fail_value"}, fail_value, 0);
    check({tag, " cycle_count"}, cycle_count, 0);
    check({tag, " store_count"}, store_count, 0);
    check({tag, " hist_cnt"}, hist_cnt, 0);
    read_hist({tag, " hist_pc"}, 0, 0);
  endtask

  initial begin
    // 1: pass at RUN cycle 20, then frozen
    do_reset();
    check_zero("reset");
    for (int i = 0; i < 20; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    check("t1 pre done", done, 0);
    check("t1 pre cycles", cycle_count, 20);
    pc = 32'd80;
    store(32'h50, 32'h7);
    tick();
    idle_inputs();
    check("t1 done", done, 1);
    check("t1 pass", pass, 1);
    check("t1 fail_code", fail_code, 0);
    check("t1 cycles", cycle_count, 21);
    check("t1 stores", store_count, 1);
    for (int i = 21; i < 26; i++) begin
      pc = 32'(i * 4);
      memwrite = 1'b1;
      tick();
    end
    idle_inputs();
    check("t1 frozen cycles", cycle_count, 21);
    check("t1 frozen stores", store_count, 1);
    check("t1 frozen hist_cnt", hist_cnt, 4);
    read_hist("t1 frozen hist0", 0, 32'd80);
    read_hist("t1 frozen hist3", 3, 32'd68);

    // 2: unrelated store, then wrong value at result address
    do_reset();
    pc = 32'h0;
    store(32'h54, 32'h7);
    tick();
    check("t2 other addr done", done, 0);
    check("t2 other addr stores", store_count, 1);
    pc = 32'h4;
    store(32'h50, 32'h3);
    tick();
    idle_inputs();
    check("t2 done", done, 1);
    check("t2 pass", pass, 0);
    check("t2 fail_code", fail_code, 1);
    check("t2 fail_value", fail_value, 3);
    check("t2 stores", store_count, 2);
    check("t2 cycles", cycle_count, 2);

    // 3: timeout after 100 RUN cycles
    do_reset();
    for (int i = 0; i < 99; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    check("t3 pre done", done, 0);
    check("t3 pre cycles", cycle_count, 99);
    pc = 32'(99 * 4);
    tick();
    check("t3 done", done, 1);
    check("t3 fail_code", fail_code, 2);
    check("t3 cycles", cycle_count, 100);

    // 4: short stall is tolerated, long stall is a hang
    do_reset();
    pc = 32'h0;  tick();
    pc = 32'h4;  tick();
    pc = 32'h1C;
    repeat (7) tick();
    pc = 32'h20; tick();
    check("t4 short stall done", done, 0);
    pc = 32'h24;
    repeat (8) tick();
    check("t4 eight samples done", done, 0);
    tick();
    check("t4 hang done", done, 1);
    check("t4 hang fail_code", fail_code, 3);
    check("t4 hang cycles", cycle_count, 19);

    // 5: history skips duplicates and overwrites the oldest
    do_reset();
    pc = 32'h0; tick();
    pc = 32'h4; tick();
    check("t5 partial hist_cnt", hist_cnt, 2);
    read_hist("t5 partial hist0", 0, 32'h4);
    read_hist("t5 partial hist1", 1, 32'h0);
    read_hist("t5 partial hist2 invalid", 2, 32'h0);
    pc = 32'h8;  tick();
    pc = 32'h8;  tick();
    pc = 32'hC;  tick();
    pc = 32'h10; tick();
    check("t5 hist_cnt", hist_cnt, 4);
    read_hist("t5 hist0", 0, 32'h10);
    read_hist("t5 hist1", 1, 32'hC);
    read_hist("t5 hist2", 2, 32'h8);
    read_hist("t5 hist3", 3, 32'h4);

    // 6: result store on the timeout boundary wins, then mid-run reset
    do_reset();
    for (int i = 0; i < 99; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    pc = 32'(99 * 4);
    store(32'h50, 32'h7);
    tick();
    idle_inputs();
    check("t6 boundary pass", pass, 1);
    check("t6 boundary fail_code", fail_code, 0);
    check("t6 boundary cycles", cycle_count, 100);
    do_reset();
    check_zero("t6 reset");
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("t6 midrun reset");
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4);
      tick();
    end
    pc = 32'hC;
    store(32'h50, 32'h9);
    tick();
    idle_inputs();
    check("t6 after fail_code", fail_code, 1);
    check("t6 after fail_value", fail_value, 9);
    check("t6 after cycles", cycle_count, 4);
    check("t6 after stores", store_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
